// File: rtl/sdhci_reset_ctrl.sv
// rtl/sdhci_reset_ctrl.sv - soft-reset sequencer: global plus per-domain reset FSMs
module sdhci_reset_ctrl #(
  parameter int unsigned           NumDomains  = 2,
  parameter int unsigned           HoldCycles  = 4,
  parameter logic [NumDomains-1:0] AutoResetEn = {NumDomains{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_reset_all_i,
  input  logic [NumDomains-1:0] sw_reset_dom_i,
  input  logic [NumDomains-1:0] auto_reset_i,
  output logic                  rst_all_no,
  output logic [NumDomains-1:0] rst_dom_no,
  output logic                  clear_all_o,
  output logic [NumDomains-1:0] clear_dom_o,
  output logic [NumDomains:0]   busy_o
);

  typedef enum logic [1:0] {IDLE, HOLD, CLEAR, WAIT} state_e;

  localparam int unsigned    CntW    = $clog2(HoldCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HoldCycles - 1);

  state_e                all_state_q, all_state_d;
  logic [CntW-1:0]       all_cnt_q, all_cnt_d;
  logic                  all_act_q;
  logic                  global_quiet;
  logic [NumDomains-1:0] auto_q;
  logic [NumDomains-1:0] auto_rise;
  logic [NumDomains-1:0] dom_act;
  logic [NumDomains-1:0] dom_busy;
  logic [NumDomains-1:0] dom_clear;

  // Global FSM next state: a level request starts HOLD, WAIT lingers while the bit stays set
  always_comb begin
    all_state_d = all_state_q;
    all_cnt_d   = all_cnt_q;
    case (all_state_q)
      IDLE: begin
        if (sw_reset_all_i) begin
          all_state_d = HOLD;
          all_cnt_d   = '0;
        end
      end
      HOLD: begin
        if (all_cnt_q == CntLast) all_state_d = CLEAR;
        else                      all_cnt_d   = all_cnt_q + CntW'(1);
      end
      CLEAR:   all_state_d = WAIT;
      WAIT:    if (!sw_reset_all_i) all_state_d = IDLE;
      default: all_state_d = IDLE;
    endcase
  end

  // Global state register; comes out of reset in HOLD so power-on gets a full stretched reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      all_state_q <= HOLD;
      all_cnt_q   <= '0;
      all_act_q   <= 1'b1;
    end else begin
      all_state_q <= all_state_d;
      all_cnt_q   <= all_cnt_d;
      all_act_q   <= (all_state_d != IDLE);
    end
  end

  // Auto-reset edge detectors keep tracking even while requests are being discarded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) auto_q <= '0;
    else         auto_q <= auto_reset_i;
  end

  assign auto_rise    = auto_reset_i & ~auto_q & AutoResetEn;
  // Domains may only act when no global reset is running or about to start this cycle
  assign global_quiet = (all_state_q == IDLE) && !sw_reset_all_i;

  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            act_q;
    logic            req;

    assign req = sw_reset_dom_i[i] | auto_rise[i];

    // Domain FSM next state; a global reset forces it idle and drops any pending request
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!global_quiet) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (req) begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end
          HOLD: begin
            if (cnt_q == CntLast) state_d = CLEAR;
            else                  cnt_d   = cnt_q + CntW'(1);
          end
          CLEAR:   state_d = WAIT;
          WAIT:    if (!sw_reset_dom_i[i]) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    // Domain state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_q   <= (state_d != IDLE);
      end
    end

    assign dom_act[i]   = act_q;
    assign dom_busy[i]  = (state_q != IDLE);
    assign dom_clear[i] = (state_q == CLEAR) && (all_state_q == IDLE);
  end

  // Assertion of rst_ni reaches the outputs combinationally; release goes through the flops
  assign rst_all_no  = rst_ni & ~all_act_q;
  assign rst_dom_no  = {NumDomains{rst_all_no}} & ~dom_act;
  assign clear_all_o = (all_state_q == CLEAR);
  assign clear_dom_o = dom_clear;
  assign busy_o      = {(all_state_q != IDLE), dom_busy};

endmodule

// File: tb/tb_sdhci_reset_ctrl.sv
// tb/tb_sdhci_reset_ctrl.sv - directed self-checking bench for sdhci_reset_ctrl
module tb_sdhci_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_all = 1'b0;
  logic [1:0] sw_dom = 2'b00;
  logic [1:0] auto = 2'b00;

  logic       rst_all_n, clr_all;
  logic [1:0] rst_dom_n, clr_dom;
  logic [2:0] busy;
  logic       rst_all_n_b, clr_all_b;
  logic [1:0] rst_dom_n_b, clr_dom_b;
  logic [2:0] busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  sdhci_reset_ctrl #(.NumDomains(2), .HoldCycles(4), .AutoResetEn(2'b11)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_reset_all_i(sw_all), .sw_reset_dom_i(sw_dom),
    .auto_reset_i(auto), .rst_all_no(rst_all_n), .rst_dom_no(rst_dom_n),
    .clear_all_o(clr_all), .clear_dom_o(clr_dom), .busy_o(busy)
  );

  sdhci_reset_ctrl #(.NumDomains(2), .HoldCycles(4), .AutoResetEn(2'b10)) u_dut_noauto (
    .clk_i(clk), .rst_ni(rst_n), .sw_reset_all_i(sw_all), .sw_reset_dom_i(sw_dom),
    .auto_reset_i(auto), .rst_all_no(rst_all_n_b), .rst_dom_no(rst_dom_n_b),
    .clear_all_o(clr_all_b), .clear_dom_o(clr_dom_b), .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after rst_ni rises; cycle 0 is the current period
  task automatic power_on_checks(input string pfx);
    for (int c = 0; c < 8; c++) begin
      check({pfx, "_rst_all"}, 32'(rst_all_n), 32'(!(c <= 5)));
      check({pfx, "_rst_dom"}, 32'(rst_dom_n), (c <= 5) ? 32'd0 : 32'd3);
      check({pfx, "_clr_all"}, 32'(clr_all), 32'(c == 4));
      check({pfx, "_busy"},    32'(busy), (c <= 5) ? 32'd4 : 32'd0);
      step();
    end
  endtask

  initial begin
    logic clr_seen;
    int   low_cnt, clr_cnt, low_cnt_b;

    // reset state and power-on stretch
    step();
    step();
    check("rst_rst_all", 32'(rst_all_n), 32'd0);
    check("rst_rst_dom", 32'(rst_dom_n), 32'd0);
    check("rst_clr",     32'({clr_all, clr_dom}), 32'd0);
    check("rst_busy",    32'(busy), 32'd4);
    rst_n = 1'b1;
    #1;
    power_on_checks("por");

    // domain 0 software reset, register clears the bit on the strobe
    for (int c = 0; c < 10; c++) begin
      if (c == 0) sw_dom[0] = 1'b1;
      check("d0_rst",     32'(rst_dom_n[0]), 32'(!(c >= 1 && c <= 6)));
      check("d0_clr",     32'(clr_dom), (c == 5) ? 32'd1 : 32'd0);
      check("d0_rst_d1",  32'(rst_dom_n[1]), 32'd1);
      check("d0_rst_all", 32'(rst_all_n), 32'd1);
      clr_seen = clr_dom[0];
      step();
      if (clr_seen) sw_dom[0] = 1'b0;
    end

    // one-cycle request pulse: HOLD still runs its full count
    for (int c = 0; c < 10; c++) begin
      sw_dom[0] = (c == 0);
      check("pulse_rst", 32'(rst_dom_n[0]), 32'(!(c >= 1 && c <= 6)));
      check("pulse_clr", 32'(clr_dom), (c == 5) ? 32'd1 : 32'd0);
      step();
    end

    // persistent auto request: single sequence; disabled instance ignores it
    low_cnt = 0; clr_cnt = 0; low_cnt_b = 0;
    for (int c = 0; c < 55; c++) begin
      auto[0] = (c < 50);
      if (c == 3) check("auto_low_c3", 32'(rst_dom_n[0]), 32'd0);
      if (!rst_dom_n[0]) low_cnt++;
      if (clr_dom[0]) clr_cnt++;
      if (!rst_dom_n_b[0]) low_cnt_b++;
      step();
    end
    auto = 2'b00;
    check("auto_low_cycles", 32'(low_cnt), 32'd6);
    check("auto_clr_count",  32'(clr_cnt), 32'd1);
    check("auto_dis_low",    32'(low_cnt_b), 32'd0);

    // global and domain 1 requested together: global wins
    for (int c = 0; c < 10; c++) begin
      if (c == 0) sw_all = 1'b1;
      sw_dom[1] = (c == 0);
      check("glb_rst_all", 32'(rst_all_n), 32'(!(c >= 1 && c <= 6)));
      check("glb_clr_all", 32'(clr_all), 32'(c == 5));
      check("glb_d1_busy", 32'(busy[1]), 32'd0);
      check("glb_clr_dom", 32'(clr_dom), 32'd0);
      clr_seen = clr_all;
      step();
      if (clr_seen) sw_all = 1'b0;
    end
    sw_dom[1] = 1'b0;
    check("glb_idle_busy", 32'(busy), 32'd0);

    // software holds domain 1 bit for 20 cycles past the strobe
    for (int c = 0; c < 30; c++) begin
      sw_dom[1] = (c <= 25);
      check("wait_rst_d1", 32'(rst_dom_n[1]), 32'(!(c >= 1 && c <= 26)));
      check("wait_clr",    32'(clr_dom), (c == 5) ? 32'd2 : 32'd0);
      check("wait_rst_d0", 32'(rst_dom_n[0]), 32'd1);
      step();
    end

    // rst_ni asserted mid domain HOLD
    sw_dom[0] = 1'b1;
    step();
    sw_dom[0] = 1'b0;
    step();
    step();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_all", 32'(rst_all_n), 32'd0);
    check("mid_rst_dom", 32'(rst_dom_n), 32'd0);
    check("mid_clr",     32'({clr_all, clr_dom}), 32'd0);
    check("mid_busy",    32'(busy), 32'd4);
    step();
    step();
    rst_n = 1'b1;
    #1;
    power_on_checks("rep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdhci_reset_ctrl.md
Name: sdhci_reset_ctrl

Overview:
- Parametrised reset sequencer for the SDHCI controller. It replaces the ad-hoc soft-reset flops in the top level.
- Generates one global soft-reset plus NumDomains sub-domain resets (default: cmd, dat) from Software Reset register bits and hardware auto-reset events (e.g. command timeout).
- Each reset is held for a guaranteed minimum time, then the block pulses a clear strobe back to the register file (hw2reg .de with .d=0) and releases the reset once the request bit reads low.

Parameters:
- NumDomains, 2, number of sub-domain resets (index 0 = cmd, 1 = dat).
- HoldCycles, 4, minimum cycles a reset stays in HOLD; legal range >= 1.
- AutoResetEn, {NumDomains{1'b1}}, per-domain enable for auto_reset_i.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sw_reset_all_i  in  1  Software Reset for All register bit (level)
- sw_reset_dom_i  in  NumDomains  per-domain Software Reset register bits (level)
- auto_reset_i  in  NumDomains  hardware auto-reset request; rising-edge sensitive
- rst_all_no  out  1  global soft reset, active-low
- rst_dom_no  out  NumDomains  sub-domain resets, active-low; always include rst_all_no
- clear_all_o  out  1  one-cycle strobe that clears the Reset All bit
- clear_dom_o  out  NumDomains  one-cycle strobes that clear the domain bits
- busy_o  out  NumDomains+1  FSM-not-IDLE flags; [NumDomains] = global

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_ni is asynchronous, active-low. All state uses FF-with-async-reset.
- rst_all_no = rst_ni & ~all_act_q.
- rst_dom_no[i] = rst_all_no & ~dom_act_q[i].
- The rst_ni assertion path is combinational, so every reset output drops immediately. Deassertion is registered only.
- One FSM for global and one per domain. States: IDLE, HOLD, CLEAR, WAIT. Counter width $clog2(HoldCycles+1).
- act_q=1 in all states except IDLE.
- Reset values:
  - Global FSM resets to HOLD, cnt=0, all_act_q=1. It therefore stretches rst_all_no low for HoldCycles+2 cycles minimum after rst_ni rises.
  - Domain FSMs reset to IDLE, dom_act_q=0.
  - clear_* = 0. Auto edge-detect flops = 0.
- IDLE -> HOLD when a request is seen. cnt := 0, act_q := 1 at that edge. rst_*_no goes low one cycle after the request cycle.
  - Global request: sw_reset_all_i = 1.
  - Domain request: sw_reset_dom_i[i] = 1, or (auto_reset_i[i] rose & AutoResetEn[i]).
- HOLD: cnt increments each cycle. HOLD exits to CLEAR after exactly HoldCycles cycles.
- CLEAR: lasts one cycle, with clear_*_o = 1 that cycle.
- WAIT: remains while the level request (sw bit) is still 1. Goes to IDLE on the first cycle it reads 0; act_q := 0 at that edge.
- Auto requests are edge-only and never hold WAIT. A persistently high timeout flag therefore triggers exactly one reset.
- Global precedence:
  - While the global FSM is not in IDLE, all domain FSMs are forced to IDLE. Domain requests and auto edges are discarded, not queued. The edge detectors keep tracking.
  - clear_dom_o is forced to 0 during a global reset.
- Domain request arriving in the same cycle as sw_reset_all_i: dropped; global wins.
- Auto edge while the domain is in HOLD, CLEAR or WAIT: absorbed; no re-trigger.
- sw bit cleared by software during HOLD: HOLD still completes its full count.
- Power-on CLEAR strobe: issued while the register file is still held by rst_all_no, so it has no effect.
- Domains are independent. Concurrent domain resets run in parallel with no ordering.
- rst_ni asserted mid-sequence: all FSMs return to their reset values immediately.

Test Plan:
- Power-on, HoldCycles=4: release rst_ni at cycle 0 -> rst_all_no low cycles 0..5, clear_all_o=1 at cycle 4, rst_all_no high from cycle 6. rst_dom_no follows rst_all_no.
- Pulse sw_reset_dom_i[0] at cycle 10; register clears it on clear_dom_o -> rst_dom_no[0] low cycles 11..16, clear_dom_o[0] at cycle 15. rst_dom_no[1] and rst_all_no stay high throughout.
- Hold auto_reset_i[0]=1 for 50 cycles -> exactly one cmd reset sequence (6 cycles low), no re-trigger. With AutoResetEn[0]=0 -> no reset at all.
- Raise sw_reset_all_i and sw_reset_dom_i[1] in the same cycle -> only the global sequence runs; domain 1 FSM stays IDLE; clear_dom_o stays 0.
- Software keeps sw_reset_dom_i[1]=1 for 20 cycles after the clear strobe -> rst_dom_no[1] stays low until one cycle after the bit drops.
- Assert rst_ni in the middle of a domain HOLD -> all outputs low in the same cycle. After release, the global power-on sequence runs and the domain FSMs are IDLE.
